regfile_scoreboard: RTL and testbench

- Parametrised multi-read-port register file for the pipelined core.
- Adds features the single-issue register file lacks:
  - configurable read-port count;
  - hardwired zero register;
  - asynchronous reset clear;
  - per-register busy scoreboard (reserve at issue, release at writeback), so decode can detect RAW hazards.
- Sits between decode/issue (reads, reservations) and writeback (writes).

---
 rtl/regfile_scoreboard.sv | 114 +++++++++++
 tb/tb_regfile_scoreboard.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with a per-register busy scoreboard.
// Decode/issue reads operands and reserves destinations; writeback
// writes results (byte-masked) and releases the reservations.
module regfile_scoreboard #(
  parameter int REG_NUMBER     = 32,
  parameter int REG_WIDTH      = 32,
  parameter int READ_PORTS     = 2,
  parameter int ZERO_REG       = 1,
  parameter int REG_ADDR_WIDTH = $clog2(REG_NUMBER),
  parameter int MASK_WIDTH     = REG_WIDTH / 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [READ_PORTS*REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [READ_PORTS*REG_WIDTH-1:0]      rd_data,
  output logic [READ_PORTS-1:0]                rd_busy,
  input  logic                                 wr_en,
  input  logic [REG_ADDR_WIDTH-1:0]            wr_addr,
  input  logic [REG_WIDTH-1:0]                 wr_data,
  input  logic [MASK_WIDTH-1:0]                wr_byte_mask,
  input  logic                                 rsv_en,
  input  logic [REG_ADDR_WIDTH-1:0]            rsv_addr,
  output logic [$clog2(REG_NUMBER+1)-1:0]      busy_count
);

  localparam int CW = $clog2(REG_NUMBER + 1);

  logic [REG_WIDTH-1:0]  regs [REG_NUMBER];
  logic [REG_NUMBER-1:0] busy;
  logic [REG_WIDTH-1:0]  merged;
  logic                  wr_ok;
  logic                  rsv_ok;
  logic                  set_new;
  logic                  clr_old;

  // Qualified write/reserve strobes: register 0 is untouchable when hardwired.
  assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // A busy bit that actually turns on, and one that actually turns off;
  // a reservation to the retiring register keeps it busy, so no clear.
  assign set_new = rsv_ok && !busy[rsv_addr];
  assign clr_old = wr_ok && busy[wr_addr] && !(rsv_ok && (rsv_addr == wr_addr));

  // Merge the writeback bytes with the currently stored value.
  always_comb begin
    merged = regs[wr_addr];
    for (int i = 0; i < MASK_WIDTH; i++) begin
      if (wr_byte_mask[i]) begin
        merged[i*8 +: 8] = wr_data[i*8 +: 8];
      end
    end
  end

  // Register storage: cleared on reset, written with the merged word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < REG_NUMBER; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= merged;
    end
  end

  // Scoreboard bits: writeback releases, issue reserves; the reserve is
  // applied last so it wins when both target the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wr_ok) begin
        busy[wr_addr] <= 1'b0;
      end
      if (rsv_ok) begin
        busy[rsv_addr] <= 1'b1;
      end
    end
  end

  // Running popcount of the busy bits, tracked incrementally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_count <= '0;
    end else begin
      case ({set_new, clr_old})
        2'b10:   busy_count <= busy_count + CW'(1);
        2'b01:   busy_count <= busy_count - CW'(1);
        default: busy_count <= busy_count;
      endcase
    end
  end

  // Combinational read ports with zero-register and writeback bypass;
  // the bypass is held off during reset so reads stay at zero.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      if ((ZERO_REG != 0) && (rd_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == '0)) begin
        rd_data[p*REG_WIDTH +: REG_WIDTH] = '0;
        rd_busy[p]                        = 1'b0;
      end else if (wr_en && !rst &&
                   (rd_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == wr_addr)) begin
        rd_data[p*REG_WIDTH +: REG_WIDTH] = merged;
        rd_busy[p]                        = 1'b0;
      end else begin
        rd_data[p*REG_WIDTH +: REG_WIDTH] = regs[rd_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
        rd_busy[p]                        = busy[rd_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed, table-driven bench for regfile_scoreboard: a 4-port instance
// with a hardwired zero register and a 1-port instance without one.
module tb_regfile_scoreboard;

  typedef struct {
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic [3:0]   mask;
    logic         rsv_en;
    logic [4:0]   rsv_addr;
    logic [19:0]  rd_addr;
    logic [127:0] exp_data;
    logic [3:0]   exp_busy;
    logic [5:0]   exp_count;
  } vec_t;

  logic         clk;
  logic         rst;
  logic [19:0]  rd_addr;
  logic [127:0] rd_data;
  logic [3:0]   rd_busy;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [3:0]   wr_byte_mask;
  logic         rsv_en;
  logic [4:0]   rsv_addr;
  logic [5:0]   busy_count;

  logic [4:0]   rd_addr_nz;
  logic [31:0]  rd_data_nz;
  logic [0:0]   rd_busy_nz;
  logic [5:0]   busy_count_nz;

  int   err_count;
  int   check_count;
  vec_t vec_q[$];

  regfile_scoreboard #(
    .REG_NUMBER(32), .REG_WIDTH(32), .READ_PORTS(4), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_mask(wr_byte_mask),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_count(busy_count)
  );

  regfile_scoreboard #(
    .REG_NUMBER(32), .REG_WIDTH(32), .READ_PORTS(1), .ZERO_REG(0)
  ) dut_nz (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr_nz), .rd_data(rd_data_nz), .rd_busy(rd_busy_nz),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_mask(wr_byte_mask),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_count(busy_count_nz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic addVec(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [3:0] m, input logic re, input logic [4:0] ra,
                        input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] a3,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3,
                        input logic [3:0] eb, input logic [5:0] ec);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.mask = m;
    v.rsv_en = re; v.rsv_addr = ra;
    v.rd_addr = {a3, a2, a1, a0};
    v.exp_data = {d3, d2, d1, d0};
    v.exp_busy = eb;
    v.exp_count = ec;
    vec_q.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one vector just after a falling edge, away from the active edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    wr_en = v.wr_en; wr_addr = v.wr_addr; wr_data = v.wr_data;
    wr_byte_mask = v.mask; rsv_en = v.rsv_en; rsv_addr = v.rsv_addr;
    rd_addr = v.rd_addr;
  endtask

  task automatic checkAllPorts(input string tag, input logic [127:0] ed,
                               input logic [3:0] eb, input logic [5:0] ec);
    for (int p = 0; p < 4; p++) begin
      checkOutput($sformatf("%s rd_data%0d", tag, p),
                  {96'd0, rd_data[p*32 +: 32]}, {96'd0, ed[p*32 +: 32]});
      checkOutput($sformatf("%s rd_busy%0d", tag, p),
                  {127'd0, rd_busy[p]}, {127'd0, eb[p]});
    end
    checkOutput($sformatf("%s busy_count", tag), {122'd0, busy_count}, {122'd0, ec});
  endtask

  task automatic idleInputs();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0; wr_byte_mask = 4'h0;
    rsv_en = 1'b0; rsv_addr = 5'd0;
  endtask

  initial begin
    err_count   = 0;
    check_count = 0;
    rst = 1'b1;
    idleInputs();
    rd_addr    = {5'd5, 5'd5, 5'd5, 5'd5};
    rd_addr_nz = 5'd0;

    //     we  wa     wd            m     re  ra     ports              expected data                                          busy   cnt
    addVec(0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  5'd5, 5'd5, 5'd5, 5'd5,   32'h0, 32'h0, 32'h0, 32'h0,                          4'b0000, 6'd0);
    addVec(1, 5'd3,  32'h11223344, 4'hF, 0, 5'd0,  5'd3, 5'd0, 5'd1, 5'd2,   32'h11223344, 32'h0, 32'h0, 32'h0,                   4'b0000, 6'd0);
    addVec(1, 5'd3,  32'hAABBCCDD, 4'h5, 0, 5'd0,  5'd3, 5'd5, 5'd5, 5'd5,   32'h11BB33DD, 32'h0, 32'h0, 32'h0,                   4'b0000, 6'd0);
    addVec(0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  5'd5, 5'd3, 5'd5, 5'd5,   32'h0, 32'h11BB33DD, 32'h0, 32'h0,                   4'b0000, 6'd0);
    addVec(1, 5'd0,  32'hFFFFFFFF, 4'hF, 1, 5'd0,  5'd0, 5'd0, 5'd5, 5'd5,   32'h0, 32'h0, 32'h0, 32'h0,                          4'b0000, 6'd0);
    addVec(0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  5'd0, 5'd3, 5'd5, 5'd5,   32'h0, 32'h11BB33DD, 32'h0, 32'h0,                   4'b0000, 6'd0);
    addVec(0, 5'd0,  32'h0,        4'h0, 1, 5'd7,  5'd7, 5'd5, 5'd5, 5'd5,   32'h0, 32'h0, 32'h0, 32'h0,                          4'b0000, 6'd0);
    addVec(0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  5'd7, 5'd5, 5'd5, 5'd5,   32'h0, 32'h0, 32'h0, 32'h0,                          4'b0001, 6'd1);
    addVec(1, 5'd7,  32'h00000055, 4'hF, 0, 5'd0,  5'd7, 5'd7, 5'd5, 5'd5,   32'h55, 32'h55, 32'h0, 32'h0,                        4'b0000, 6'd1);
    addVec(0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  5'd7, 5'd5, 5'd5, 5'd5,   32'h55, 32'h0, 32'h0, 32'h0,                         4'b0000, 6'd0);
    addVec(1, 5'd12, 32'hDEADBEEF, 4'hF, 1, 5'd9,  5'd12, 5'd9, 5'd5, 5'd5,  32'hDEADBEEF, 32'h0, 32'h0, 32'h0,                   4'b0000, 6'd0);
    addVec(0, 5'd0,  32'h0,        4'h0, 1, 5'd2,  5'd9, 5'd5, 5'd5, 5'd5,   32'h0, 32'h0, 32'h0, 32'h0,                          4'b0001, 6'd1);
    addVec(1, 5'd9,  32'h12345678, 4'hF, 1, 5'd9,  5'd9, 5'd9, 5'd2, 5'd5,   32'h12345678, 32'h12345678, 32'h0, 32'h0,            4'b0100, 6'd2);
    addVec(0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  5'd9, 5'd2, 5'd5, 5'd5,   32'h12345678, 32'h0, 32'h0, 32'h0,                   4'b0011, 6'd2);
    addVec(1, 5'd9,  32'h0A0B0C0D, 4'hF, 1, 5'd4,  5'd9, 5'd4, 5'd5, 5'd5,   32'h0A0B0C0D, 32'h0, 32'h0, 32'h0,                   4'b0000, 6'd2);
    addVec(0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  5'd12, 5'd12, 5'd12, 5'd2, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,    4'b1000, 6'd2);
    addVec(0, 5'd0,  32'h0,        4'h0, 1, 5'd4,  5'd4, 5'd5, 5'd5, 5'd5,   32'h0, 32'h0, 32'h0, 32'h0,                          4'b0001, 6'd2);
    addVec(0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  5'd4, 5'd9, 5'd5, 5'd5,   32'h0, 32'h0A0B0C0D, 32'h0, 32'h0,                   4'b0001, 6'd2);
    addVec(1, 5'd5,  32'hFFFFFF77, 4'h1, 0, 5'd0,  5'd5, 5'd5, 5'd5, 5'd5,   32'h77, 32'h77, 32'h77, 32'h77,                      4'b0000, 6'd2);
    addVec(0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  5'd5, 5'd4, 5'd2, 5'd12,  32'h77, 32'h0, 32'h0, 32'hDEADBEEF,                  4'b0110, 6'd2);

    // Release reset on a falling edge after a couple of cycles.
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vec_q[i]) begin
      applyStimulus(vec_q[i]);
      #2;
      checkAllPorts($sformatf("v%0d", i), vec_q[i].exp_data, vec_q[i].exp_busy,
                    vec_q[i].exp_count);
    end

    // Without a hardwired zero, register 0 keeps the write and the reservation.
    @(negedge clk);
    idleInputs();
    rd_addr_nz = 5'd0;
    #2;
    checkOutput("nz reg0 data", {96'd0, rd_data_nz}, {96'd0, 32'hFFFFFFFF});
    checkOutput("nz reg0 busy", {127'd0, rd_busy_nz[0]}, 128'd1);

    // Asynchronous reset mid-cycle with a write and reservation presented.
    @(negedge clk);
    rd_addr = {5'd5, 5'd2, 5'd4, 5'd12};
    #2;
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h12121212; wr_byte_mask = 4'hF;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    #1;
    checkAllPorts("async rst", 128'd0, 4'b0000, 6'd0);
    @(negedge clk);
    #2;
    checkAllPorts("held rst", 128'd0, 4'b0000, 6'd0);

    // After release: nothing from the reset window stuck, old reservations gone.
    @(negedge clk);
    rst = 1'b0;
    idleInputs();
    rd_addr = {5'd2, 5'd4, 5'd6, 5'd12};
    #2;
    checkAllPorts("post rst", 128'd0, 4'b0000, 6'd0);

    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h99; wr_byte_mask = 4'hF;
    rd_addr = {5'd5, 5'd5, 5'd5, 5'd4};
    #2;
    checkAllPorts("post rst wb", {96'd0, 32'h99}, 4'b0000, 6'd0);

    @(negedge clk);
    idleInputs();
    #2;
    checkAllPorts("post rst wb2", {96'd0, 32'h99}, 4'b0000, 6'd0);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
